// File: rtl/zipdbg_seq.sv
// Debug access sequencer: turns a single CPU-register read/write request into the
// halt/select control write, the data-register access and an optional release write.
module zipdbg_seq #(
  parameter int unsigned LGTIMEOUT = 10
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  // request side
  input  logic        i_req_stb,
  output logic        o_req_busy,
  input  logic        i_req_we,
  input  logic [4:0]  i_req_reg,
  input  logic [31:0] i_req_data,
  input  logic        i_req_resume,
  // response side
  output logic        o_rsp_stb,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_err,
  // debug wishbone master
  output logic        o_dbg_cyc,
  output logic        o_dbg_stb,
  output logic        o_dbg_we,
  output logic        o_dbg_addr,
  output logic [31:0] o_dbg_data,
  input  logic        i_dbg_ack,
  input  logic        i_dbg_stall,
  input  logic [31:0] i_dbg_data
);

  typedef enum logic [2:0] {StIdle, StCmd, StData, StResume, StDone} state_e;

  localparam logic [LGTIMEOUT-1:0] TimerOne  = {{(LGTIMEOUT-1){1'b0}}, 1'b1};
  localparam logic [LGTIMEOUT-1:0] TimerMax  = {LGTIMEOUT{1'b1}};
  // Last count before all-ones: the edge leaving it is the timeout edge.
  localparam logic [LGTIMEOUT-1:0] TimerLast = {{(LGTIMEOUT-1){1'b1}}, 1'b0};

  state_e                 state_q, state_d;
  logic                   stb_q, stb_d;
  logic [LGTIMEOUT-1:0]   timer_q, timer_d;
  logic                   we_q, we_d;
  logic [4:0]             reg_q, reg_d;
  logic [31:0]            data_q, data_d;
  logic                   resume_q, resume_d;
  logic [31:0]            rsp_data_q, rsp_data_d;
  logic                   rsp_err_q, rsp_err_d;
  logic                   busy;
  logic                   phase_done;

  assign busy = (state_q == StCmd) || (state_q == StData) || (state_q == StResume);
  // An ack only counts once the strobe is (or is being) accepted.
  assign phase_done = busy && i_dbg_ack && (!stb_q || !i_dbg_stall);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      stb_q      <= 1'b0;
      timer_q    <= '0;
      we_q       <= 1'b0;
      reg_q      <= '0;
      data_q     <= '0;
      resume_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      stb_q      <= stb_d;
      timer_q    <= timer_d;
      we_q       <= we_d;
      reg_q      <= reg_d;
      data_q     <= data_d;
      resume_q   <= resume_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    stb_d      = stb_q;
    timer_d    = timer_q;
    we_d       = we_q;
    reg_d      = reg_q;
    data_d     = data_q;
    resume_d   = resume_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (i_req_stb) begin
          state_d  = StCmd;
          stb_d    = 1'b1;
          timer_d  = '0;
          we_d     = i_req_we;
          reg_d    = i_req_reg;
          data_d   = i_req_data;
          resume_d = i_req_resume;
        end
      end
      StCmd, StData, StResume: begin
        if (stb_q && !i_dbg_stall) begin
          stb_d = 1'b0;
        end
        if (timer_q != TimerMax) begin
          timer_d = timer_q + TimerOne;
        end
        if (phase_done) begin
          timer_d = '0;
          stb_d   = 1'b1;
          if (state_q == StCmd) begin
            state_d = StData;
          end else if (state_q == StData) begin
            rsp_data_d = i_dbg_data;
            rsp_err_d  = 1'b0;
            if (resume_q) begin
              state_d = StResume;
            end else begin
              state_d = StDone;
              stb_d   = 1'b0;
            end
          end else begin
            state_d = StDone;
            stb_d   = 1'b0;
          end
        end else if (timer_q == TimerLast) begin
          state_d    = StDone;
          stb_d      = 1'b0;
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
        stb_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    o_dbg_we   = 1'b0;
    o_dbg_addr = 1'b0;
    o_dbg_data = '0;
    unique case (state_q)
      StCmd: begin
        o_dbg_we   = 1'b1;
        o_dbg_data = {21'd0, 1'b1, 5'd0, reg_q};
      end
      StData: begin
        o_dbg_we   = we_q;
        o_dbg_addr = 1'b1;
        o_dbg_data = we_q ? data_q : 32'd0;
      end
      StResume: begin
        o_dbg_we   = 1'b1;
        o_dbg_data = {27'd0, reg_q};
      end
      default: ;
    endcase
  end

  assign o_dbg_cyc  = busy;
  assign o_dbg_stb  = stb_q;
  assign o_req_busy = busy;
  assign o_rsp_stb  = (state_q == StDone);
  assign o_rsp_data = rsp_data_q;
  assign o_rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_zipdbg_seq.sv
// Directed bench for zipdbg_seq with a scripted debug-bus slave (per-transaction stall/ack plan).
module tb_zipdbg_seq;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_req_stb;
  logic        o_req_busy;
  logic        i_req_we;
  logic [4:0]  i_req_reg;
  logic [31:0] i_req_data;
  logic        i_req_resume;
  logic        o_rsp_stb;
  logic [31:0] o_rsp_data;
  logic        o_rsp_err;
  logic        o_dbg_cyc;
  logic        o_dbg_stb;
  logic        o_dbg_we;
  logic        o_dbg_addr;
  logic [31:0] o_dbg_data;
  logic        i_dbg_ack;
  logic        i_dbg_stall;
  logic [31:0] i_dbg_data;

  int checks = 0;
  int errors = 0;

  // slave script and observation log, indexed by accepted-transaction number
  int          stall_plan [0:7];
  logic        ack_plan   [0:7];
  logic [31:0] rdata_plan [0:7];
  logic [33:0] txn_log    [0:7];
  int          txn_idx    = 0;
  int          stall_seen = 0;
  int          stall_tot  = 0;
  int          cyc_cnt    = 0;
  int          rsp_cnt    = 0;

  zipdbg_seq #(
    .LGTIMEOUT(4)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req_stb   (i_req_stb),
    .o_req_busy  (o_req_busy),
    .i_req_we    (i_req_we),
    .i_req_reg   (i_req_reg),
    .i_req_data  (i_req_data),
    .i_req_resume(i_req_resume),
    .o_rsp_stb   (o_rsp_stb),
    .o_rsp_data  (o_rsp_data),
    .o_rsp_err   (o_rsp_err),
    .o_dbg_cyc   (o_dbg_cyc),
    .o_dbg_stb   (o_dbg_stb),
    .o_dbg_we    (o_dbg_we),
    .o_dbg_addr  (o_dbg_addr),
    .o_dbg_data  (o_dbg_data),
    .i_dbg_ack   (i_dbg_ack),
    .i_dbg_stall (i_dbg_stall),
    .i_dbg_data  (i_dbg_data)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Scripted slave: acks (or not) the cycle after each accepted strobe.
  initial begin
    logic        ack_next;
    logic [31:0] data_next;
    i_dbg_ack   = 1'b0;
    i_dbg_stall = 1'b0;
    i_dbg_data  = 32'd0;
    forever begin
      @(posedge i_clk);
      ack_next  = 1'b0;
      data_next = 32'd0;
      if (o_dbg_cyc) cyc_cnt++;
      if (o_rsp_stb) rsp_cnt++;
      if (o_dbg_cyc && o_dbg_stb) begin
        if (i_dbg_stall) begin
          stall_seen++;
          stall_tot++;
        end else begin
          if (txn_idx < 8) begin
            txn_log[txn_idx] = {o_dbg_addr, o_dbg_we, o_dbg_data};
            ack_next  = ack_plan[txn_idx];
            data_next = rdata_plan[txn_idx];
          end
          txn_idx++;
          stall_seen = 0;
        end
      end
      #1;
      i_dbg_ack   = ack_next;
      i_dbg_data  = ack_next ? data_next : 32'd0;
      i_dbg_stall = (txn_idx < 8) && (stall_seen < stall_plan[txn_idx]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge i_clk);
    #2;
  endtask

  task automatic set_plan(input int s0, input int s1, input int s2,
                          input logic a0, input logic a1, input logic a2);
    for (int i = 0; i < 8; i++) begin
      stall_plan[i] = 0;
      ack_plan[i]   = 1'b1;
      rdata_plan[i] = 32'h1111_0000 + i;
      txn_log[i]    = '0;
    end
    stall_plan[0] = s0;
    stall_plan[1] = s1;
    stall_plan[2] = s2;
    ack_plan[0]   = a0;
    ack_plan[1]   = a1;
    ack_plan[2]   = a2;
    txn_idx    = 0;
    stall_seen = 0;
    stall_tot  = 0;
    cyc_cnt    = 0;
    rsp_cnt    = 0;
  endtask

  // Presents a request for one edge, then scrambles the inputs to prove they were latched.
  task automatic issue(input logic we, input logic [4:0] rg, input logic [31:0] d,
                       input logic res);
    i_req_stb    = 1'b1;
    i_req_we     = we;
    i_req_reg    = rg;
    i_req_data   = d;
    i_req_resume = res;
    step();
    i_req_stb    = 1'b0;
    i_req_we     = ~we;
    i_req_reg    = ~rg;
    i_req_data   = ~d;
    i_req_resume = ~res;
  endtask

  task automatic wait_rsp(input int bound, output int lat);
    lat = -1;
    for (int n = 1; n <= bound; n++) begin
      step();
      if (o_rsp_stb) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({o_dbg_cyc, o_dbg_stb, o_dbg_we, o_dbg_addr} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_dbg_ctrl: got %b, required 0000",
               {o_dbg_cyc, o_dbg_stb, o_dbg_we, o_dbg_addr});
    end
    checks++;
    if ({o_req_busy, o_rsp_stb, o_rsp_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_status: got %b, required 000", {o_req_busy, o_rsp_stb, o_rsp_err});
    end
    checks++;
    if ({o_dbg_data, o_rsp_data} !== 64'd0) begin
      errors++;
      $display("FAIL reset_data: got dbg %h rsp %h, required 0 0", o_dbg_data, o_rsp_data);
    end
  endtask

  task automatic test_read();
    int lat;
    set_plan(0, 0, 0, 1'b1, 1'b1, 1'b1);
    rdata_plan[1] = 32'hDEAD_BEEF;
    issue(1'b0, 5'd5, 32'h0BAD_F00D, 1'b0);
    checks++;
    if ({o_dbg_cyc, o_dbg_stb, o_dbg_addr, o_dbg_we, o_req_busy} !== 5'b11011) begin
      errors++;
      $display("FAIL read_cmd_after_accept: got %b, required 11011",
               {o_dbg_cyc, o_dbg_stb, o_dbg_addr, o_dbg_we, o_req_busy});
    end
    wait_rsp(40, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL read_latency: got %0d, required 4", lat);
    end
    checks++;
    if ({o_rsp_err, o_rsp_data} !== {1'b0, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL read_rsp: got err %b data %h, required err 0 data deadbeef",
               o_rsp_err, o_rsp_data);
    end
    checks++;
    if (o_req_busy !== 1'b0 || o_dbg_cyc !== 1'b0) begin
      errors++;
      $display("FAIL read_done_idle: got busy %b cyc %b, required 0 0", o_req_busy, o_dbg_cyc);
    end
    checks++;
    if (txn_idx !== 2 || txn_log[0] !== {1'b0, 1'b1, 32'h0000_0405}
        || txn_log[1] !== {1'b1, 1'b0, 32'h0000_0000}) begin
      errors++;
      $display("FAIL read_txns: got n=%0d t0=%h t1=%h, required n=2 t0=1_00000405 t1=2_00000000",
               txn_idx, txn_log[0], txn_log[1]);
    end
    step();
    checks++;
    if (o_rsp_stb !== 1'b0 || cyc_cnt !== 4 || o_rsp_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL read_pulse_cyc: got stb %b cyc_cycles %0d data %h, required 0 4 deadbeef",
               o_rsp_stb, cyc_cnt, o_rsp_data);
    end
  endtask

  task automatic test_write_resume();
    int lat;
    set_plan(0, 0, 0, 1'b1, 1'b1, 1'b1);
    issue(1'b1, 5'd31, 32'h1234_5678, 1'b1);
    wait_rsp(40, lat);
    checks++;
    if (lat !== 6) begin
      errors++;
      $display("FAIL wr_resume_latency: got %0d, required 6", lat);
    end
    checks++;
    if (txn_idx !== 3 || txn_log[0] !== {1'b0, 1'b1, 32'h0000_041F}
        || txn_log[1] !== {1'b1, 1'b1, 32'h1234_5678}
        || txn_log[2] !== {1'b0, 1'b1, 32'h0000_001F}) begin
      errors++;
      $display("FAIL wr_resume_txns: got n=%0d %h %h %h, required 3 1_0000041f 3_12345678 1_0000001f",
               txn_idx, txn_log[0], txn_log[1], txn_log[2]);
    end
    checks++;
    if (o_rsp_err !== 1'b0 || cyc_cnt !== 6) begin
      errors++;
      $display("FAIL wr_resume_err_cyc: got err %b cyc_cycles %0d, required 0 6",
               o_rsp_err, cyc_cnt);
    end
  endtask

  task automatic test_stall();
    int lat;
    set_plan(3, 2, 0, 1'b1, 1'b1, 1'b1);
    rdata_plan[1] = 32'h0000_ABCD;
    issue(1'b0, 5'd2, 32'd0, 1'b0);
    wait_rsp(40, lat);
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL stall_latency: got %0d, required 9", lat);
    end
    checks++;
    if (stall_tot !== 5 || txn_idx !== 2) begin
      errors++;
      $display("FAIL stall_stb_held: got stalled_edges %0d txns %0d, required 5 2",
               stall_tot, txn_idx);
    end
    checks++;
    if (o_rsp_data !== 32'h0000_ABCD || txn_log[0] !== {1'b0, 1'b1, 32'h0000_0402}) begin
      errors++;
      $display("FAIL stall_data: got rsp %h t0 %h, required 0000abcd 1_00000402",
               o_rsp_data, txn_log[0]);
    end
  endtask

  task automatic test_timeout();
    int lat;
    set_plan(0, 0, 0, 1'b1, 1'b0, 1'b1);
    issue(1'b0, 5'd9, 32'd0, 1'b1);
    step();
    step();
    checks++;
    if ({o_dbg_stb, o_dbg_addr} !== 2'b11) begin
      errors++;
      $display("FAIL timeout_data_entry: got stb %b addr %b, required 1 1", o_dbg_stb, o_dbg_addr);
    end
    wait_rsp(40, lat);
    checks++;
    if (lat !== 15) begin
      errors++;
      $display("FAIL timeout_latency: got %0d edges after data entry, required 15", lat);
    end
    checks++;
    if ({o_rsp_err, o_rsp_data} !== {1'b1, 32'd0} || o_dbg_cyc !== 1'b0 || o_dbg_stb !== 1'b0) begin
      errors++;
      $display("FAIL timeout_rsp: got err %b data %h cyc %b stb %b, required 1 0 0 0",
               o_rsp_err, o_rsp_data, o_dbg_cyc, o_dbg_stb);
    end
    step();
    step();
    checks++;
    if (txn_idx !== 2 || o_dbg_cyc !== 1'b0 || o_rsp_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_no_resume: got txns %0d cyc %b err %b, required 2 0 1",
               txn_idx, o_dbg_cyc, o_rsp_err);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    set_plan(0, 0, 0, 1'b1, 1'b1, 1'b1);
    i_req_stb    = 1'b1;
    i_req_we     = 1'b0;
    i_req_reg    = 5'd1;
    i_req_data   = 32'd0;
    i_req_resume = 1'b0;
    step();
    i_req_we     = 1'b1;
    i_req_reg    = 5'd7;
    i_req_data   = 32'hA5A5_0000;
    wait_rsp(40, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL b2b_first_latency: got %0d, required 4", lat);
    end
    step();
    i_req_stb = 1'b0;
    checks++;
    if ({o_dbg_cyc, o_dbg_stb, o_dbg_addr, o_dbg_data} !== {1'b1, 1'b1, 1'b0, 32'h0000_0407}) begin
      errors++;
      $display("FAIL b2b_next_cmd: got cyc %b stb %b addr %b data %h, required 1 1 0 00000407",
               o_dbg_cyc, o_dbg_stb, o_dbg_addr, o_dbg_data);
    end
    wait_rsp(40, lat);
    checks++;
    if (lat !== 4 || txn_log[3] !== {1'b1, 1'b1, 32'hA5A5_0000}) begin
      errors++;
      $display("FAIL b2b_second: got lat %0d t3 %h, required 4 3_a5a50000", lat, txn_log[3]);
    end
    step();
    step();
    step();
    checks++;
    if (rsp_cnt !== 2 || o_req_busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_rsp_count: got %0d busy %b, required 2 0", rsp_cnt, o_req_busy);
    end
  endtask

  task automatic test_reset_mid();
    int rsp_snap;
    set_plan(0, 0, 0, 1'b1, 1'b1, 1'b1);
    issue(1'b0, 5'd3, 32'd0, 1'b0);
    step();
    step();
    step();
    rsp_snap = rsp_cnt;
    i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_dbg_cyc, o_dbg_stb, o_req_busy, o_rsp_stb} !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_immediate: got cyc %b stb %b busy %b rsp %b, required 0000",
               o_dbg_cyc, o_dbg_stb, o_req_busy, o_rsp_stb);
    end
    i_rst_n = 1'b1;
    step();
    step();
    step();
    step();
    checks++;
    if (rsp_cnt !== rsp_snap || o_req_busy !== 1'b0 || o_dbg_cyc !== 1'b0) begin
      errors++;
      $display("FAIL midreset_idle: got rsp_pulses %0d busy %b cyc %b, required %0d 0 0",
               rsp_cnt, o_req_busy, o_dbg_cyc, rsp_snap);
    end
    checks++;
    if ({o_rsp_err, o_rsp_data} !== 33'd0) begin
      errors++;
      $display("FAIL midreset_rsp_cleared: got err %b data %h, required 0 0",
               o_rsp_err, o_rsp_data);
    end
  endtask

  initial begin
    i_rst_n      = 1'b0;
    i_req_stb    = 1'b0;
    i_req_we     = 1'b0;
    i_req_reg    = 5'd0;
    i_req_data   = 32'd0;
    i_req_resume = 1'b0;
    set_plan(0, 0, 0, 1'b1, 1'b1, 1'b1);
    step();
    step();
    test_reset();
    i_rst_n = 1'b1;
    step();
    test_read();
    test_write_resume();
    test_stall();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/zipdbg_seq.md
# zipdbg_seq

Debug access sequencer sitting directly upstream of the CPU's debug Wishbone slave port. Turns a single "read/write CPU register N" request into the two-step debug protocol: a control-register write (halt + register index), then a data-register access, and optionally a final control write that releases the halt. Returns the data-phase read value, or a timeout error, through a single-pulse response.

## Interface
- LGTIMEOUT, 10, log2 of the per-phase ack timeout; a phase times out after 2^LGTIMEOUT-1 cycles without ack.
- i_clk  in  1  system clock; all logic on posedge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req_stb  in  1  request valid; accepted on any edge where i_req_stb && !o_req_busy.
- o_req_busy  out  1  sequencer occupied; requests ignored while high.
- i_req_we  in  1  1 = write CPU register, 0 = read.
- i_req_reg  in  5  CPU register index (0..31).
- i_req_data  in  32  write data for a register write.
- i_req_resume  in  1  1 = release the halt after the data phase.
- o_rsp_stb  out  1  one-cycle completion pulse.
- o_rsp_data  out  32  data-phase read value; valid while o_rsp_stb.
- o_rsp_err  out  1  timeout flag; valid while o_rsp_stb.
- o_dbg_cyc, o_dbg_stb, o_dbg_we  out  1 each  debug Wishbone master controls.
- o_dbg_addr  out  1  0 = control register, 1 = data register.
- o_dbg_data  out  32  debug write data.
- i_dbg_ack, i_dbg_stall  in  1 each  slave acknowledge / stall.
- i_dbg_data  in  32  slave read data.

## Operation
- States: IDLE, CMD, DATA, RESUME, DONE.
- On acceptance, latch we, reg, data, resume; later changes to the request inputs are ignored until the next acceptance.
- CMD: o_dbg_addr=0, o_dbg_we=1, o_dbg_data=32'h0000_0400 | reg (halt bit 10 set; reset bit 6, step bit 8, and cache-clear bit 11 all zero).
- DATA: o_dbg_addr=1, o_dbg_we=latched we, o_dbg_data = latched data for writes, 0 for reads.
- RESUME, only when resume is latched: o_dbg_addr=0, o_dbg_we=1, o_dbg_data=32'h0000_0000 | reg (halt clear).
- Per phase: o_dbg_stb is asserted on phase entry and held while i_dbg_stall. It drops on the edge it is accepted (stb && !stall). The sequencer then waits for i_dbg_ack; one transaction is outstanding at a time.
- An ack seen on the same edge as stb acceptance completes the phase.
- i_dbg_ack while o_dbg_cyc=0, or while stb is high and stalled, is ignored.
- o_dbg_cyc is high continuously from CMD entry through the final phase's ack or timeout, and low in IDLE and DONE.
- Phase advance on ack: CMD→DATA; DATA→RESUME if resume, else DONE; RESUME→DONE.
- On the DATA-phase ack, capture i_dbg_data into o_rsp_data.
- Timeout counter, LGTIMEOUT bits:
  - clears on each phase entry and increments every cycle of the phase; saturates, never wraps.
  - Reaching all-ones without ack goes to DONE with o_rsp_err=1 and o_rsp_data=0.
  - cyc and stb drop on that same edge, and the remaining phases are skipped.
- DONE lasts one cycle: o_rsp_stb=1, o_req_busy=0, then IDLE.
- o_rsp_err and o_rsp_data hold their values until the next DONE.
- o_req_busy=1 in CMD, DATA, RESUME; 0 in IDLE and DONE.
- A request presented during DONE is accepted: CMD is entered directly on the next edge.

## Timing
- Reset (async assert, sync-released logic): state IDLE; o_dbg_cyc, o_dbg_stb, o_dbg_we, o_dbg_addr, o_req_busy, o_rsp_stb, o_rsp_err = 0; o_dbg_data and o_rsp_data = 0; timeout counter 0.
- Reset asserted mid-transaction drops o_dbg_cyc and o_dbg_stb immediately with no response pulse. A late ack after release is ignored.
- Acceptance edge E0 → CMD outputs visible after E0.
- Zero stall with ack one cycle after accept: ack seen at E2, DATA stb after E2, DATA ack at E4, o_rsp_stb high after E4.
- Latency is 4 edges from acceptance to response without resume, 6 with resume. Each stall cycle or extra ack-wait cycle adds one.
- Timeout response: o_rsp_stb high exactly 2^LGTIMEOUT-1 edges after entry of the failing phase, when no ack arrives.

## Test plan
- Read r5, slave with zero stall and 1-cycle ack returning 32'hDEADBEEF in DATA. Required: control write 32'h405 with addr=0, then read with addr=1; o_rsp_stb 4 edges after acceptance with o_rsp_data=32'hDEADBEEF and o_rsp_err=0; o_dbg_cyc high for exactly 4 cycles.
- Write r31=32'h1234_5678 with resume=1. Required: three phases with data 32'h41F, 32'h1234_5678 (we=1, addr=1), then 32'h1F; response 6 edges after acceptance.
- Slave stalls 3 cycles in CMD and 2 in DATA. Required: o_dbg_stb held through the stalls; o_rsp_stb 9 edges after acceptance.
- Slave never acks DATA, LGTIMEOUT=4. Required: o_rsp_stb 15 edges after DATA entry with o_rsp_err=1 and o_rsp_data=0; cyc low afterward; RESUME skipped.
- Back-to-back: second request held high during the first's DONE cycle. Required: accepted that edge; next CMD stb appears the cycle after o_rsp_stb.
- i_rst_n pulsed low during DATA; stray ack after release. Required: cyc and stb low immediately, no o_rsp_stb, FSM stays IDLE.
